// File: rtl/imem_port_arb.sv
// imem_port_arb
// Arbiter and sequencer for the single-port synchronous instruction memory.
// Shares the memory between the CPU fetch port (read-only) and the
// debug/loader port (read/write). Fetch addresses that are misaligned or out
// of bounds, and debug addresses that are out of bounds, are answered with
// fault responses without touching the memory.
//
// Configuration macro:
//   IMEM_ARB_DBG_PRIO_EN  defined   -> debug always wins memory-port conflicts
//                         undefined -> round-robin on conflicts (default)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_req/f_addr/f_gnt            fetch request handshake (gnt combinational)
//   f_rvalid/f_rdata              fetch response (one cycle after grant)
//   f_exc_en/f_exc_code/f_exc_val fetch fault report (0 misaligned, 1 access)
//   d_req/d_we/d_addr/d_wdata     debug request, d_gnt combinational
//   d_rvalid/d_rdata/d_err        debug response (one cycle after grant)
//   mem_en/mem_we/mem_idx/mem_wdata/mem_rdata  memory port, rdata one cycle late

module imem_port_arb #(
   parameter int MEM_SIZE = 2048,
   parameter int IDX_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_req,
   input  logic [63:0]      f_addr,
   output logic             f_gnt,
   output logic             f_rvalid,
   output logic [31:0]      f_rdata,
   output logic             f_exc_en,
   output logic [3:0]       f_exc_code,
   output logic [63:0]      f_exc_val,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [63:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [31:0]      d_rdata,
   output logic             d_err,
   output logic             mem_en,
   output logic             mem_we,
   output logic [IDX_W-1:0] mem_idx,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Full-width bounds check: every address bit above the word index must be
   // zero, so high-address aliases of low words are rejected.
   function automatic logic addr_oob(input logic [63:0] addr);
      return |addr[63:IDX_W+2];
   endfunction

   logic f_mis_s, f_oob_s, f_fault_s, d_oob_s;
   logic f_mem_req_s, d_mem_req_s, conflict_s, f_wins_s;
   logic f_gnt_s, d_gnt_s, f_mem_gnt_s, d_mem_gnt_s;
   logic unused_d_lo_s;

   logic        f_rvalid_r, f_mem_r, f_exc_en_r;
   logic [3:0]  f_exc_code_r;
   logic [63:0] f_exc_val_r;
   logic [31:0] f_rdata_r;
   logic        d_rvalid_r, d_rd_r, d_err_r;
   logic [31:0] d_rdata_r;

   assign f_mis_s     = |f_addr[1:0];
   assign f_oob_s     = addr_oob(f_addr);
   assign f_fault_s   = f_mis_s | f_oob_s;
   assign d_oob_s     = addr_oob(d_addr);
   assign unused_d_lo_s = ^d_addr[1:0];

   assign f_mem_req_s = f_req & ~f_fault_s;
   assign d_mem_req_s = d_req & ~d_oob_s;
   assign conflict_s  = f_mem_req_s & d_mem_req_s;

`ifdef IMEM_ARB_DBG_PRIO_EN
   assign f_wins_s = 1'b0;
`else
   logic last_d_r;

   // Round-robin memory: set when debug won the most recent conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_r <= 1'b1;
      end else if (conflict_s) begin
         last_d_r <= ~last_d_r;
      end
   end

   assign f_wins_s = last_d_r;
`endif

   // Grant: faulting requests never need the port, so they are always taken.
   always_comb begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (rst) begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else begin
         f_gnt_s = f_req & (f_fault_s | ~d_mem_req_s | f_wins_s);
         d_gnt_s = d_req & (d_oob_s | ~f_mem_req_s | ~f_wins_s);
      end
   end

   assign f_mem_gnt_s = f_gnt_s & ~f_fault_s;
   assign d_mem_gnt_s = d_gnt_s & ~d_oob_s;

   // Memory port drive; all fields are zero when no access is made.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_idx   = {IDX_W{1'b0}};
      mem_wdata = 32'h0000_0000;
      if (d_mem_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_idx   = d_addr[IDX_W+1:2];
         mem_wdata = d_we ? d_wdata : 32'h0000_0000;
      end else if (f_mem_gnt_s) begin
         mem_en    = 1'b1;
         mem_idx   = f_addr[IDX_W+1:2];
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Fetch response registers. rdata_r holds fault data immediately and
   // captures memory data at the end of its response cycle so it persists.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_rvalid_r   <= 1'b0;
         f_mem_r      <= 1'b0;
         f_exc_en_r   <= 1'b0;
         f_exc_code_r <= 4'd0;
         f_exc_val_r  <= 64'd0;
         f_rdata_r    <= 32'h0000_0000;
      end else begin
         f_rvalid_r <= f_gnt_s;
         if (f_gnt_s) begin
            f_mem_r      <= ~f_fault_s;
            f_exc_en_r   <= f_fault_s;
            f_exc_code_r <= (f_fault_s && !f_mis_s) ? 4'd1 : 4'd0;
            f_exc_val_r  <= f_fault_s ? f_addr : 64'd0;
         end
         if (f_gnt_s && f_fault_s) begin
            f_rdata_r <= NOP_INSN;
         end else if (f_rvalid_r && f_mem_r) begin
            f_rdata_r <= mem_rdata;
         end
      end
   end

   // Debug response registers, same hold scheme as fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_rvalid_r <= 1'b0;
         d_rd_r     <= 1'b0;
         d_err_r    <= 1'b0;
         d_rdata_r  <= 32'h0000_0000;
      end else begin
         d_rvalid_r <= d_gnt_s;
         if (d_gnt_s) begin
            d_rd_r  <= ~d_oob_s & ~d_we;
            d_err_r <= d_oob_s;
         end
         if (d_gnt_s && (d_oob_s || d_we)) begin
            d_rdata_r <= 32'h0000_0000;
         end else if (d_rvalid_r && d_rd_r) begin
            d_rdata_r <= mem_rdata;
         end
      end
   end

   // A response pending while rst is high is suppressed.
   assign f_gnt      = f_gnt_s;
   assign d_gnt      = d_gnt_s;
   assign f_rvalid   = f_rvalid_r & ~rst;
   assign f_rdata    = (f_rvalid_r && f_mem_r && !rst) ? mem_rdata : f_rdata_r;
   assign f_exc_en   = f_exc_en_r;
   assign f_exc_code = f_exc_code_r;
   assign f_exc_val  = f_exc_val_r;
   assign d_rvalid   = d_rvalid_r & ~rst;
   assign d_rdata    = (d_rvalid_r && d_rd_r && !rst) ? mem_rdata : d_rdata_r;
   assign d_err      = d_err_r;

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed self-checking bench for imem_port_arb with a behavioural
// synchronous memory. Inputs change on the falling edge; combinational
// outputs are checked 1 ns later, registered outputs 1 ns after the rising edge.
module tb_imem_port_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, f_gnt, f_rvalid, f_exc_en;
   logic [63:0] f_addr, f_exc_val;
   logic [31:0] f_rdata;
   logic [3:0]  f_exc_code;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [63:0] d_addr;
   logic [31:0] d_wdata, d_rdata;
   logic        mem_en, mem_we;
   logic [10:0] mem_idx;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] mem [0:2047];
   int n_chk = 0;
   int n_fail = 0;
   logic [4:0] exp_fwin;
   logic       exp_post_rst_f;

   imem_port_arb #(.MEM_SIZE(2048), .IDX_W(11)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_exc_en(f_exc_en), .f_exc_code(f_exc_code),
      .f_exc_val(f_exc_val),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory: read data appears one cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_idx] <= mem_wdata;
         else        mem_rdata    <= mem[mem_idx];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [63:0] fa,
                        input logic dr, input logic dw, input logic [63:0] da,
                        input logic [31:0] dd);
      @(negedge clk);
      f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      #1;
   endtask

   task automatic edge_wait;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem[2] = 32'h00a0_0093;
      mem_rdata = 32'h0;
`ifdef IMEM_ARB_DBG_PRIO_EN
      exp_fwin = 5'b00000;
      exp_post_rst_f = 1'b0;
`else
      exp_fwin = 5'b10101;
      exp_post_rst_f = 1'b1;
`endif
      rst = 1'b1;
      f_req = 1'b1; f_addr = 64'h8; d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 32'h0;
      #1;
      chk("rst_fgnt", {63'd0, f_gnt}, 64'd0);
      chk("rst_memen", {63'd0, mem_en}, 64'd0);
      edge_wait; edge_wait;
      chk("rst_frvalid", {63'd0, f_rvalid}, 64'd0);
      chk("rst_frdata", {32'd0, f_rdata}, 64'd0);
      chk("rst_fexcval", f_exc_val, 64'd0);
      chk("rst_derr", {63'd0, d_err}, 64'd0);

      // Aligned in-bounds fetch, issued twice back to back.
      drive(1'b1, 64'h8, 1'b0, 1'b0, 64'h0, 32'h0);
      rst = 1'b0; #1;
      chk("f8_gnt", {63'd0, f_gnt}, 64'd1);
      chk("f8_memen", {63'd0, mem_en}, 64'd1);
      chk("f8_idx", {53'd0, mem_idx}, 64'd2);
      edge_wait;
      chk("f8_rvalid", {63'd0, f_rvalid}, 64'd1);
      chk("f8_rdata", {32'd0, f_rdata}, 64'h00a00093);
      chk("f8_exc", {63'd0, f_exc_en}, 64'd0);
      drive(1'b1, 64'h8, 1'b0, 1'b0, 64'h0, 32'h0);
      edge_wait;
      chk("f8b_rvalid", {63'd0, f_rvalid}, 64'd1);
      chk("f8b_rdata", {32'd0, f_rdata}, 64'h00a00093);
      drive(1'b0, 64'h8, 1'b0, 1'b0, 64'h0, 32'h0);
      edge_wait;
      chk("idle_rvalid", {63'd0, f_rvalid}, 64'd0);
      chk("idle_hold", {32'd0, f_rdata}, 64'h00a00093);

      // Misaligned fetch.
      drive(1'b1, 64'h6, 1'b0, 1'b0, 64'h0, 32'h0);
      chk("f6_gnt", {63'd0, f_gnt}, 64'd1);
      chk("f6_memen", {63'd0, mem_en}, 64'd0);
      edge_wait;
      chk("f6_exc", {63'd0, f_exc_en}, 64'd1);
      chk("f6_code", {60'd0, f_exc_code}, 64'd0);
      chk("f6_val", f_exc_val, 64'h6);
      chk("f6_rdata", {32'd0, f_rdata}, 64'h13);

      // Out-of-bounds fetches, including one whose truncated index is 0.
      drive(1'b1, 64'h2000, 1'b0, 1'b0, 64'h0, 32'h0);
      chk("f2000_memen", {63'd0, mem_en}, 64'd0);
      edge_wait;
      chk("f2000_code", {60'd0, f_exc_code}, 64'd1);
      chk("f2000_val", f_exc_val, 64'h2000);
      drive(1'b1, 64'h1_0000_0000, 1'b0, 1'b0, 64'h0, 32'h0);
      chk("fhi_memen", {63'd0, mem_en}, 64'd0);
      edge_wait;
      chk("fhi_code", {60'd0, f_exc_code}, 64'd1);
      chk("fhi_val", f_exc_val, 64'h1_0000_0000);
      // Last valid word.
      drive(1'b1, 64'h1ffc, 1'b0, 1'b0, 64'h0, 32'h0);
      chk("flast_memen", {63'd0, mem_en}, 64'd1);
      chk("flast_idx", {53'd0, mem_idx}, 64'd2047);
      edge_wait;
      chk("flast_exc", {63'd0, f_exc_en}, 64'd0);

      // Out-of-bounds debug read.
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h2000, 32'h0);
      chk("doob_gnt", {63'd0, d_gnt}, 64'd1);
      chk("doob_memen", {63'd0, mem_en}, 64'd0);
      edge_wait;
      chk("doob_rvalid", {63'd0, d_rvalid}, 64'd1);
      chk("doob_err", {63'd0, d_err}, 64'd1);
      chk("doob_rdata", {32'd0, d_rdata}, 64'd0);

      // Misaligned fetch alongside a debug write: both granted.
      drive(1'b1, 64'h6, 1'b1, 1'b1, 64'h10, 32'hdeadbeef);
      chk("mix_fgnt", {63'd0, f_gnt}, 64'd1);
      chk("mix_dgnt", {63'd0, d_gnt}, 64'd1);
      chk("mix_we", {63'd0, mem_we}, 64'd1);
      chk("mix_idx", {53'd0, mem_idx}, 64'd4);
      chk("mix_wdata", {32'd0, mem_wdata}, 64'hdeadbeef);
      edge_wait;
      chk("mix_fexc", {63'd0, f_exc_en}, 64'd1);
      chk("mix_drvalid", {63'd0, d_rvalid}, 64'd1);
      chk("mix_derr", {63'd0, d_err}, 64'd0);
      drive(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 32'h0);
      edge_wait;
      chk("f10_rdata", {32'd0, f_rdata}, 64'hdeadbeef);

      // Conflicts: fetch 0x8 vs debug read 0x10 for five cycles.
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 64'h8, 1'b1, 1'b0, 64'h10, 32'h0);
         chk($sformatf("conf%0d_fgnt", c), {63'd0, f_gnt}, {63'd0, exp_fwin[c]});
         chk($sformatf("conf%0d_dgnt", c), {63'd0, d_gnt}, {63'd0, ~exp_fwin[c]});
         edge_wait;
         if (exp_fwin[c]) chk($sformatf("conf%0d_frd", c), {32'd0, f_rdata}, 64'h00a00093);
         else             chk($sformatf("conf%0d_drd", c), {32'd0, d_rdata}, 64'hdeadbeef);
      end

      // Reset in the cycle after a faulting fetch grant.
      drive(1'b1, 64'h6, 1'b0, 1'b0, 64'h0, 32'h0);
      chk("pre_rst_gnt", {63'd0, f_gnt}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("rstcyc_rvalid", {63'd0, f_rvalid}, 64'd0);
      chk("rstcyc_gnt", {63'd0, f_gnt}, 64'd0);
      edge_wait;
      chk("postrst_exc", {63'd0, f_exc_en}, 64'd0);
      chk("postrst_code", {60'd0, f_exc_code}, 64'd0);
      chk("postrst_val", f_exc_val, 64'd0);
      chk("postrst_rdata", {32'd0, f_rdata}, 64'd0);
      chk("postrst_drdata", {32'd0, d_rdata}, 64'd0);
      drive(1'b1, 64'h8, 1'b1, 1'b0, 64'h10, 32'h0);
      rst = 1'b0; #1;
      chk("postrst_conf_f", {63'd0, f_gnt}, {63'd0, exp_post_rst_f});
      chk("postrst_conf_d", {63'd0, d_gnt}, {63'd0, ~exp_post_rst_f});
      edge_wait;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_port_arb.md
# imem_port_arb

Arbiter and sequencer for the single-port synchronous instruction memory of the RV64 core. It shares the memory between the CPU fetch port (read-only) and the debug/loader port (read/write) under round-robin priority. It also screens fetch addresses for misalignment and out-of-bounds accesses, and returns those as precise fault responses instead of memory accesses. It sits between the fetch stage / debug module and the instruction memory array.

## Interface
- MEM_SIZE, 2048, memory depth in 32-bit words (power of two)
- IDX_W, 11, word-index width, log2(MEM_SIZE)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- f_req  in  1  fetch request; held with f_addr until f_gnt
- f_addr  in  64  fetch byte address (PC)
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch response valid (registered)
- f_rdata  out  32  fetched instruction; 32'h00000013 on fault
- f_exc_en  out  1  response carries a fault
- f_exc_code  out  4  0 = misaligned, 1 = access fault
- f_exc_val  out  64  faulting address (mtval)
- d_req  in  1  debug request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  64  debug byte address
- d_wdata  in  32  write data
- d_gnt  out  1  debug request accepted (combinational)
- d_rvalid  out  1  debug response valid, for reads and writes (registered)
- d_rdata  out  32  read data; 0 on error or write
- d_err  out  1  out-of-bounds debug access
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_idx  out  IDX_W  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid one cycle after mem_en

## Operation
**Address checks**
- In-bounds iff full-width addr[63:2] < MEM_SIZE; truncated compares are forbidden.
- mem_idx = addr[IDX_W+1:2].
- Fetch fault priority: misaligned (f_addr[1:0] != 0, code 0) over out-of-bounds (code 1).
- Debug: low address bits are ignored. Out-of-bounds sets d_err; writes are dropped.

**Grant**
- A faulting request (fetch fault or debug out-of-bounds) is granted immediately and does not use the memory port. The other requester may use the port in the same cycle.
- Only one memory-using request is granted per cycle.
- On conflict, the port goes to the requester not granted at the last conflict (`last_d` flag). `last_d` updates only on conflicts.

**Response**
- Response registers load one cycle after the grant.
- f_rdata/d_rdata come from mem_rdata for memory accesses, or are the fault values.
- Outputs hold their last values while rvalid is 0.
- Each port has at most one response per cycle; back-to-back grants yield back-to-back responses.

## Timing
- Grant cycle N → response (rvalid=1) at cycle N+1. rvalid is a one-cycle pulse per grant.
- mem_en/mem_we/mem_idx/mem_wdata are combinational in cycle N and low when idle.
- Requester handshake: f_addr/d_* must stay stable while req=1 and gnt=0. Deasserting req before grant withdraws the request with no response.

**Reset**
- rst at a clock edge clears f_rvalid, d_rvalid, f_exc_en, f_exc_code, f_exc_val, f_rdata, d_rdata and d_err to 0.
- `last_d` is set to 1, so fetch wins the first conflict.
- Any response due in the cycle after reset is discarded.
- While rst=1: gnt=0, mem_en=0.

## Configuration
- IMEM_ARB_DBG_PRIO_EN defined: debug has fixed priority over fetch on every conflict; `last_d` is unused.
- Undefined (default): round-robin as above.

## Test plan
- Fetch only, f_addr=0x8 each cycle with memory word 2 = 0x00a00093 → f_gnt same cycle; f_rvalid next cycle with f_rdata=0x00a00093, f_exc_en=0.
- f_addr=0x6 → granted, no mem_en; next cycle f_exc_en=1, code 0, f_exc_val=0x6, f_rdata=0x13.
- f_addr=0x2000 (word 2048), then f_addr=0x1_0000_0000 (truncated index 0) → both code 1, exc_val equal to each address, mem_en=0.
- f_req and d_req held high 4 cycles after reset, both in-bounds → grants F,D,F,D. With IMEM_ARB_DBG_PRIO_EN → D,D,D,D.
- Fetch misaligned and debug write to 0x10 (data 0xdeadbeef) in the same cycle → both granted; mem_we=1, mem_idx=4; a later fetch at 0x10 returns 0xdeadbeef.
- rst asserted in the cycle after a grant → no rvalid; all outputs 0; first post-reset conflict granted to fetch.
